// File: rtl/exc_pkg.sv
// Shared types and constants for the exception handler: FSM states,
// EStatus cause codes and the recognised opcode encodings.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    HANDLER = 2'd2
  } state_t;

  localparam logic [3:0] ES_NONE  = 4'b0000;
  localparam logic [3:0] ES_EXTL  = 4'b0001;
  localparam logic [3:0] ES_INVOP = 4'b0010;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ERET = 11'b11010110100;
  // CBZ only fixes the upper 8 bits; the low 3 are don't-care
  localparam logic [7:0]  OP_CBZ_HI = 8'b10110100;

  localparam logic [7:0]  CNT_MAX = 8'hFF;

endpackage

// File: rtl/exc_handler_if.sv
// Decode/datapath-side signal bundle of the exception handler.
// master = the datapath/requester side, slave = the handler.
interface exc_handler_if;
  logic [10:0] instr;
  logic        instr_valid;
  logic        ExtlRQ;
  logic        ExcAck;
  logic        Exc;
  logic        ExtlAck;
  logic [3:0]  EStatus;
  logic        ERet;
  logic [7:0]  exc_count;

  modport master (
    output instr, instr_valid, ExtlRQ, ExcAck,
    input  Exc, ExtlAck, EStatus, ERet, exc_count
  );

  modport slave (
    input  instr, instr_valid, ExtlRQ, ExcAck,
    output Exc, ExtlAck, EStatus, ERet, exc_count
  );
endinterface

// File: rtl/exc_handler_opcode_check.sv
// Combinational opcode classifier: flags legal opcodes and ERET.
module opcode_check
  import exc_pkg::*;
(
  input  logic [10:0] instr,
  output logic        is_valid,
  output logic        is_eret
);

  // match against the legal opcode table; CBZ compares its fixed bits only
  always_comb begin
    is_eret  = (instr == OP_ERET);
    is_valid = 1'b0;
    unique case (instr)
      OP_LDUR, OP_STUR, OP_ADD, OP_SUB,
      OP_AND, OP_ORR, OP_ERET: is_valid = 1'b1;
      default:                 is_valid = (instr[10:3] == OP_CBZ_HI);
    endcase
  end

endmodule

// File: rtl/exc_handler.sv
// Exception handler: detects invalid opcodes and external interrupts in
// IDLE, holds Exc until the datapath acknowledges, then waits in HANDLER
// for ERET. Counts taken exceptions (saturating).
module exc_handler
  import exc_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  exc_handler_if.slave  bus
);

  state_t     state, state_n;
  logic [3:0] status, status_n;
  logic [7:0] cnt, cnt_n;
  logic       exc_q, extl_ack_q, extl_ack_n;
  logic       is_valid, is_eret, eret;

  opcode_check u_opc (
    .instr    (bus.instr),
    .is_valid (is_valid),
    .is_eret  (is_eret)
  );

  // next state, cause code, counter and strobes
  always_comb begin
    state_n    = state;
    status_n   = status;
    cnt_n      = cnt;
    extl_ack_n = 1'b0;
    eret       = 1'b0;
    unique case (state)
      IDLE: begin
        // an ERET outside a handler is treated as an illegal instruction
        if (bus.instr_valid && (!is_valid || is_eret)) begin
          state_n  = PEND;
          status_n = ES_INVOP;
        end else if (bus.ExtlRQ) begin
          state_n  = PEND;
          status_n = ES_EXTL;
        end
      end
      PEND: begin
        if (bus.ExcAck) begin
          state_n    = HANDLER;
          cnt_n      = (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
          extl_ack_n = (status == ES_EXTL);
        end
      end
      HANDLER: begin
        // no nesting: ExtlRQ and bad opcodes are ignored here
        if (bus.instr_valid && is_eret) begin
          eret     = 1'b1;
          state_n  = IDLE;
          status_n = ES_NONE;
        end
      end
      default: begin
        state_n  = IDLE;
        status_n = ES_NONE;
      end
    endcase
  end

  // state and registered outputs; reset aborts without any acknowledge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      status     <= ES_NONE;
      cnt        <= 8'd0;
      exc_q      <= 1'b0;
      extl_ack_q <= 1'b0;
    end else begin
      state      <= state_n;
      status     <= status_n;
      cnt        <= cnt_n;
      exc_q      <= (state_n == PEND);
      extl_ack_q <= extl_ack_n;
    end
  end

  assign bus.Exc       = exc_q;
  assign bus.ExtlAck   = extl_ack_q;
  assign bus.EStatus   = status;
  assign bus.ERet      = eret;
  assign bus.exc_count = cnt;

endmodule

// File: tb/tb_exc_handler.sv
// Directed bench for exc_handler. Inputs change 1ns after a rising edge;
// outputs are sampled 1ns after an edge (or 1ns after an input change for
// the combinational ERet).
module tb_exc_handler;
  import exc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  exc_handler_if bus();

  exc_handler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // advance one rising edge, then settle 1ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.instr       = 11'd0;
    bus.instr_valid = 1'b0;
    bus.ExtlRQ      = 1'b0;
    bus.ExcAck      = 1'b0;
    reset           = 1'b0;
    #12;
    check("rst_exc",     {7'd0, bus.Exc},     8'd0);
    check("rst_extlack", {7'd0, bus.ExtlAck}, 8'd0);
    check("rst_estatus", {4'd0, bus.EStatus}, 8'd0);
    check("rst_count",   bus.exc_count,       8'd0);
    check("rst_eret",    {7'd0, bus.ERet},    8'd0);
    reset = 1'b1;
    tick();

    // external request detected on the first edge after reset
    bus.ExtlRQ = 1'b1;
    tick();
    check("ext_exc",     {7'd0, bus.Exc},     8'd1);
    check("ext_estatus", {4'd0, bus.EStatus}, 8'd1);
    check("ext_noack",   {7'd0, bus.ExtlAck}, 8'd0);

    // PEND holds without ack; ERET opcode must not produce ERet here
    bus.instr = OP_ERET; bus.instr_valid = 1'b1;
    #1;
    check("pend_eret0", {7'd0, bus.ERet}, 8'd0);
    tick();
    check("pend_hold", {7'd0, bus.Exc}, 8'd1);

    // acknowledge: ExtlAck for exactly one cycle, count 1
    bus.instr_valid = 1'b0; bus.ExtlRQ = 1'b0; bus.ExcAck = 1'b1;
    tick();
    check("ack_exc0",    {7'd0, bus.Exc},     8'd0);
    check("ack_extlack", {7'd0, bus.ExtlAck}, 8'd1);
    check("ack_count",   bus.exc_count,       8'd1);
    bus.ExcAck = 1'b0;
    tick();
    check("ack_pulse1", {7'd0, bus.ExtlAck}, 8'd0);

    // HANDLER masks ExtlRQ and invalid opcodes for 10 cycles
    bus.ExtlRQ = 1'b1; bus.instr = 11'h7FF; bus.instr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hnd_exc0",    {7'd0, bus.Exc},     8'd0);
      check("hnd_estatus", {4'd0, bus.EStatus}, 8'd1);
    end

    // ERET in HANDLER: ERet same cycle, IDLE with cleared cause next cycle
    bus.ExtlRQ = 1'b0; bus.instr = OP_ERET;
    #1;
    check("hnd_eret1", {7'd0, bus.ERet}, 8'd1);
    tick();
    bus.instr_valid = 1'b0;
    #1;
    check("ret_estatus", {4'd0, bus.EStatus}, 8'd0);
    check("ret_eret0",   {7'd0, bus.ERet},    8'd0);
    check("ret_exc0",    {7'd0, bus.Exc},     8'd0);

    // legal opcodes and stray ExcAck in IDLE do nothing
    bus.instr = OP_ADD; bus.instr_valid = 1'b1; bus.ExcAck = 1'b1;
    tick();
    check("add_noexc", {7'd0, bus.Exc}, 8'd0);
    check("idle_ack_count", bus.exc_count, 8'd1);
    bus.instr = 11'b10110100101; bus.ExcAck = 1'b0;
    tick();
    check("cbz_noexc", {7'd0, bus.Exc}, 8'd0);

    // invalid opcode wins over simultaneous ExtlRQ
    bus.instr = 11'b11111111111; bus.ExtlRQ = 1'b1;
    tick();
    check("prio_exc",     {7'd0, bus.Exc},     8'd1);
    check("prio_estatus", {4'd0, bus.EStatus}, 8'd2);
    bus.instr_valid = 1'b0; bus.ExcAck = 1'b1;
    tick();
    check("inv_noextlack", {7'd0, bus.ExtlAck}, 8'd0);
    check("inv_count",     bus.exc_count,       8'd2);
    bus.ExcAck = 1'b0; bus.instr = OP_ERET; bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    // ExtlRQ still high in IDLE -> second exception
    tick();
    check("second_exc",     {7'd0, bus.Exc},     8'd1);
    check("second_estatus", {4'd0, bus.EStatus}, 8'd1);

    // async reset mid-cycle while in PEND with ExcAck pending
    bus.ExcAck = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("arst_exc",     {7'd0, bus.Exc},     8'd0);
    check("arst_estatus", {4'd0, bus.EStatus}, 8'd0);
    check("arst_count",   bus.exc_count,       8'd0);
    tick();
    check("arst_noextlack", {7'd0, bus.ExtlAck}, 8'd0);
    bus.ExcAck = 1'b0; bus.ExtlRQ = 1'b0;
    #2;
    reset = 1'b1;
    tick();

    // 260 acknowledged exceptions saturate the counter at 255
    for (int i = 0; i < 260; i++) begin
      bus.ExtlRQ = 1'b1;
      tick();
      bus.ExtlRQ = 1'b0; bus.ExcAck = 1'b1;
      tick();
      bus.ExcAck = 1'b0; bus.instr = OP_ERET; bus.instr_valid = 1'b1;
      tick();
      bus.instr_valid = 1'b0;
      if (i == 253) check("cnt_254", bus.exc_count, 8'd254);
    end
    check("cnt_sat", bus.exc_count, 8'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exc_handler.md
EXC_HANDLER -- requirements
Module: exc_handler

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset; 0 forces the reset state immediately, independent of clk.
REQ-003 SHALL have port instr, input, 11, opcode field of the instruction in decode this cycle.
REQ-004 SHALL have port instr_valid, input, 1, instr holds a real instruction, not a bubble.
REQ-005 SHALL have port ExtlRQ, input, 1, level-sensitive external interrupt request.
REQ-006 SHALL have port ExcAck, input, 1, datapath has redirected PC to the exception vector.
REQ-007 SHALL have port Exc, output, 1, exception request to datapath; registered.
REQ-008 SHALL have port ExtlAck, output, 1, one-cycle acknowledge to the external requester; registered.
REQ-009 SHALL have port EStatus, output, 4, cause code of the active exception; registered.
REQ-010 SHALL have port ERet, output, 1, exception-return strobe to datapath; combinational.
REQ-011 SHALL have port exc_count, output, 8, saturating count of exceptions taken; registered.

Function
REQ-012 SHALL implement states IDLE, PEND and HANDLER.
REQ-013 SHALL define EStatus codes: 4'b0000 none, 4'b0001 external, 4'b0010 invalid opcode.
REQ-014 SHALL treat these instr values as valid: LDUR 11111000010, STUR 11111000000, ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, CBZ 10110100xxx, ERET 11010110100.
REQ-015 IDLE: if instr_valid and instr is not valid, or is ERET, SHALL next-state to PEND with EStatus=0010.
REQ-016 IDLE: else if ExtlRQ=1, SHALL next-state to PEND with EStatus=0001.
REQ-017 IDLE: an invalid opcode and ExtlRQ in the same cycle SHALL give invalid opcode priority; ExtlRQ is left pending.
REQ-018 Exc SHALL be 1 exactly while in PEND, first asserting the cycle after detection (1-cycle latency).
REQ-019 PEND: Exc SHALL hold until ExcAck=1 is sampled, with no timeout.
REQ-020 PEND: on sampling ExcAck=1, SHALL go to HANDLER and increment exc_count, saturating at 255.
REQ-021 PEND: on sampling ExcAck=1 with EStatus=0001, SHALL pulse ExtlAck high for exactly the next cycle.
REQ-022 PEND: instr and ExtlRQ SHALL be ignored.
REQ-023 HANDLER: ExtlRQ SHALL be masked, with no nesting.
REQ-024 HANDLER: invalid opcodes SHALL be ignored and EStatus held.
REQ-025 HANDLER: instr_valid with ERET SHALL drive ERet=1 in that same cycle, next-state IDLE, EStatus cleared to 0000 on that edge.
REQ-026 ERet SHALL be 0 in IDLE and PEND, even for an ERET opcode.
REQ-027 IDLE: ExtlRQ still high on return to IDLE SHALL trigger a new exception; the requester must drop ExtlRQ after ExtlAck.
REQ-028 ExcAck outside PEND SHALL be ignored.

Reset
REQ-029 reset=0 SHALL force state IDLE.
REQ-030 reset=0 SHALL force Exc=0, ExtlAck=0, EStatus=0000 and exc_count=0.
REQ-031 Reset during PEND or HANDLER SHALL abort without ExtlAck.
REQ-032 After reset deasserts, the first detection SHALL be possible on the first clk edge.

Structure
REQ-033 Package exc_pkg SHALL hold the state enum, the EStatus codes and the opcode constants.
REQ-034 Sub-module opcode_check SHALL be combinational, with inputs instr and outputs is_valid and is_eret.

Verification
REQ-035 Reset, then ExtlRQ=1 in IDLE -> Exc=1 next cycle, EStatus=0001.
REQ-036 Continuing REQ-035: ExcAck=1 at cycle 4 -> ExtlAck pulse at cycle 5 only, exc_count=1.
REQ-037 instr=11111111111 with instr_valid=1 and ExtlRQ=1 together -> EStatus=0010.
REQ-038 Continuing REQ-037: after ack and ERET -> second exception, EStatus=0001.
REQ-039 In HANDLER, ExtlRQ=1 for 10 cycles -> Exc stays 0, EStatus unchanged.
REQ-040 In HANDLER, instr=11010110100 with instr_valid=1 -> ERet=1 same cycle, IDLE and EStatus=0000 next cycle.
REQ-041 reset=0 mid-clock while in PEND -> Exc=0 and EStatus=0000 immediately, no ExtlAck.
REQ-042 260 acknowledged exceptions -> exc_count=255.
